// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared AES-128 decrypt definitions: inverse S-box, round count, FSM states
// and GF(2^8) helpers. Byte k of a 128-bit block is blk[127-8k -: 8], row k%4, col k/4.
package aes_dec_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] b);
    return gf_xtime(gf_xtime(gf_xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
    return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
    return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(gf_xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
    return gf_xtime(gf_xtime(gf_xtime(b))) ^ gf_xtime(gf_xtime(b)) ^ gf_xtime(b);
  endfunction

  // Row r rotates right by r: out[r][c] takes in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      src = (k % 4) + 4 * (((k / 4) - (k % 4) + 4) % 4);
      o[127-8*k -: 8] = s[127-8*src -: 8];
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_inv_mix_column.sv
// InvMixColumns on one column: circulant [0e 0b 0d 09] over GF(2^8), poly 0x11b.
// col_i[31:24] is row 0.
module inv_mix_column
  import aes_dec_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign col_o[31:24] = gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3);
  assign col_o[23:16] = gf_mul09(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3);
  assign col_o[15:8]  = gf_mul0d(a0) ^ gf_mul09(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3);
  assign col_o[7:0]   = gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2) ^ gf_mul0e(a3);

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor, one inverse round per clock, round keys fetched by index.
// Optional AES_INV_ZEROIZE_EN: clear plaintext on consumption and mask out_text when idle.
module aes_inv_cipher_iter
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         busy
);

  // Handshakes: a transfer happens on the clock edge where valid and ready are
  // both high; valid, once raised, holds with stable data until that edge.

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] st_q, st_d;

  logic [127:0] isr, isb, ark, imc;

  assign isr = inv_shift_rows(st_q);

  for (genvar k = 0; k < 16; k++) begin : g_isb
    assign isb[127-8*k -: 8] = INV_SBOX[isr[127-8*k -: 8]];
  end

  assign ark = isb ^ rk;

  for (genvar c = 0; c < 4; c++) begin : g_imc
    inv_mix_column u_imc (
      .col_i(ark[127-32*c -: 32]),
      .col_o(imc[127-32*c -: 32])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'(NR - 1);
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    st_d      = st_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = 4'(NR);
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d    = in_text ^ rk;
          cnt_d   = 4'(NR - 1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        busy   = 1'b1;
        rk_idx = cnt_q;
        st_d   = imc;
        if (cnt_q == 4'd1) state_d = FINAL;
        else               cnt_d   = cnt_q - 4'd1;
      end
      FINAL: begin
        busy    = 1'b1;
        rk_idx  = 4'd0;
        st_d    = ark;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
`ifdef AES_INV_ZEROIZE_EN
          st_d    = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AES_INV_ZEROIZE_EN
  assign out_text = out_valid ? st_q : '0;
`else
  assign out_text = st_q;
`endif

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: FIPS-197 C.1, backpressure, back-to-back,
// mid-run reset and ignored-input checks against a byte-level reference model.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_text;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_text;
  logic         busy;

  aes_inv_cipher_iter dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_text(in_text),
    .rk_idx(rk_idx), .rk(rk),
    .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- reference tables and key store ----------------
  localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;

  logic [7:0]   sbox_t  [256];
  logic [7:0]   isbox_t [256];
  logic [127:0] rk_tab  [11];

  assign rk = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] exp_q[$];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_tables();
    logic [7:0]  inv, s;
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    int r, c;
    for (int k = 0; k < 16; k++) s[k] = ct[127-8*k -: 8] ^ rk_tab[10][127-8*k -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int k = 0; k < 16; k++) begin
        r = k % 4;
        c = k / 4;
        t[k] = isbox_t[s[r + 4*((c + 4 - r) % 4)]] ^ rk_tab[rnd][127-8*k -: 8];
      end
      if (rnd > 0) begin
        for (int cc = 0; cc < 4; cc++) begin
          s[4*cc]   = gmul(t[4*cc], 8'h0e) ^ gmul(t[4*cc+1], 8'h0b) ^ gmul(t[4*cc+2], 8'h0d) ^ gmul(t[4*cc+3], 8'h09);
          s[4*cc+1] = gmul(t[4*cc], 8'h09) ^ gmul(t[4*cc+1], 8'h0e) ^ gmul(t[4*cc+2], 8'h0b) ^ gmul(t[4*cc+3], 8'h0d);
          s[4*cc+2] = gmul(t[4*cc], 8'h0d) ^ gmul(t[4*cc+1], 8'h09) ^ gmul(t[4*cc+2], 8'h0e) ^ gmul(t[4*cc+3], 8'h0b);
          s[4*cc+3] = gmul(t[4*cc], 8'h0b) ^ gmul(t[4*cc+1], 8'h0d) ^ gmul(t[4*cc+2], 8'h09) ^ gmul(t[4*cc+3], 8'h0e);
        end
      end else begin
        s = t;
      end
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- driver: one block, called at a negedge with DUT idle ----------------
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input int bp,
                           input bit noisy, output int acc_cyc);
    logic [43:0] seen;
    int  c;
    bit  got_ov;
    seen   = '0;
    got_ov = 1'b0;
    in_valid = 1'b1;
    in_text  = ct;
    c = 0;
    while (!in_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    acc_cyc = cyc;
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready low for 20 cycles");
      in_valid = 1'b0;
      return;
    end
    seen = {seen[39:0], rk_idx};
    exp_q.push_back(pt);
    c = 0;
    while (c < 30) begin
      @(negedge clk);
      c++;
      if (out_valid) begin
        got_ov = 1'b1;
        break;
      end
      if (c <= 10) seen = {seen[39:0], rk_idx};
      if (c == 5) check("busy_mid", 128'(busy), 128'd1);
      in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) in_text = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    in_valid = 1'b0;
    if (!got_ov) begin
      n_cmp++;
      n_bad++;
      $display("FAIL out_valid_timeout: no out_valid within 30 cycles");
      void'(exp_q.pop_front());
      return;
    end
    check("latency", 128'(c), 128'd11);
    check("rk_idx_seq", 128'(seen), 128'h0A9876543210);
    check("busy_done", 128'(busy), 128'd0);
    out_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_out_text", out_text, pt);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    check("out_valid_held", 128'(out_valid), 128'd1);
    check("out_text", out_text, exp_q.pop_front());
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", 128'(out_valid), 128'd0);
    check("post_in_ready", 128'(in_ready), 128'd1);
`ifdef AES_INV_ZEROIZE_EN
    check("post_out_text", out_text, 128'd0);
`else
    check("post_out_text", out_text, pt);
`endif
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
    int           bp;
  } vec_t;

  vec_t vecs [4];
  int   acc  [4];

  initial begin
    int a, c;
    rst = 1'b1;
    in_valid = 1'b0;
    in_text = '0;
    out_ready = 1'b0;
    build_tables();

    vecs[0] = '{C1_CT, C1_PT, 0};
    vecs[1] = '{128'd0, model_decrypt(128'd0), 0};
    vecs[2] = '{C1_CT, C1_PT, 20};
    vecs[3] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97,
                model_decrypt(128'h3ad77bb40d7a3660a89ecaf32466ef97), 3};

    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_text", out_text, 128'd0);
    check("rst_rk_idx", 128'(rk_idx), 128'd10);
    rst = 1'b0;
    @(negedge clk);

    // vecs[0] and vecs[1] run back to back with the input offered immediately.
    for (int i = 0; i < 4; i++) run_block(vecs[i].ct, vecs[i].pt, vecs[i].bp, 1'b0, acc[i]);
    check("b2b_spacing_ge12", 128'((acc[1] - acc[0]) >= 12), 128'd1);

    // Reset in the middle of ROUND, at round key index 5.
    in_valid = 1'b1;
    in_text  = C1_CT;
    @(negedge clk);
    in_valid = 1'b0;
    c = 0;
    while (rk_idx != 4'd5 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("mid_rk_idx", 128'(rk_idx), 128'd5);
    check("mid_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_in_ready", 128'(in_ready), 128'd1);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_out_text", out_text, 128'd0);
    check("abort_rk_idx", 128'(rk_idx), 128'd10);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_block(C1_CT, C1_PT, 0, 1'b0, a);

    // Random in_valid/in_text activity while busy must not disturb the block.
    run_block(C1_CT, C1_PT, 2, 1'b1, a);
    run_block(128'd0, vecs[1].pt, 0, 1'b1, a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
